// File: rtl/write_buffer_d.sv
// rtl/write_buffer_d.sv - cache write buffer driving AXI W/B channels; WBUF_WAIT_BRESP_EN waits for the B response
module write_buffer_d #(
  parameter int LINE_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wbuf_we,
  input  logic                     wbuf_reset,
  input  logic                     uncache,
  input  logic [32*LINE_BEATS-1:0] line_data,
  input  logic [31:0]              un_data,
  input  logic [3:0]               un_strb,
  input  logic                     w_req,
  input  logic                     w_rdy_AXI,
  input  logic                     w_ready,
  input  logic                     b_valid,
  output logic                     w_valid,
  output logic [31:0]              w_data,
  output logic [3:0]               w_strb,
  output logic                     w_last,
  output logic                     b_ready,
  output logic                     wrt_AXI_finish,
  output logic                     busy
);

  localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LINE_BEATS - 1);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_FULL   = 5'b00010,
    S_SEND   = 5'b00100,
    S_WAIT_B = 5'b01000,
    S_DONE   = 5'b10000
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     line_q [LINE_BEATS];
  logic [31:0]     un_data_q;
  logic [3:0]      un_strb_q;
  logic            uncache_q;
  logic            load_en;
  logic            last_beat;

  // A capture is only honoured while no line is pending or in flight.
  assign load_en   = wbuf_we && ((state == S_IDLE) || (state == S_DONE));
  // Uncached stores are a single beat, so beat 0 is also the last one.
  assign last_beat = uncache_q ? (cnt == '0) : (cnt == LAST_IDX);

  // Latch the victim line and uncached store when a capture is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LINE_BEATS; i++) line_q[i] <= '0;
      un_data_q <= '0;
      un_strb_q <= '0;
      uncache_q <= 1'b0;
    end else if (load_en) begin
      for (int i = 0; i < LINE_BEATS; i++) line_q[i] <= line_data[i*32 +: 32];
      un_data_q <= un_data;
      un_strb_q <= un_strb;
      uncache_q <= uncache;
    end
  end

  // Buffer state machine and beat counter; a started burst always runs to completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en) begin
            state <= S_FULL;
            cnt   <= '0;
          end
        end
        S_FULL: begin
          if (w_req && w_rdy_AXI) begin
            state <= S_SEND;
          end else if (wbuf_reset) begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (w_ready) begin
            if (last_beat) begin
              cnt <= '0;
`ifdef WBUF_WAIT_BRESP_EN
              state <= S_WAIT_B;
`else
              state <= S_DONE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef WBUF_WAIT_BRESP_EN
        S_WAIT_B: begin
          if (b_valid) begin
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (load_en) begin
            state <= S_FULL;
            cnt   <= '0;
          end else if (wbuf_reset) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // W channel is decoded purely from state, counter and stored data.
  assign w_valid        = (state == S_SEND);
  assign w_data         = (state == S_SEND) ? (uncache_q ? un_data_q : line_q[cnt]) : 32'h0;
  assign w_strb         = (state == S_SEND) ? (uncache_q ? un_strb_q : 4'hF) : 4'h0;
  assign w_last         = (state == S_SEND) && last_beat;
  assign wrt_AXI_finish = (state == S_DONE);
  assign busy           = (state == S_SEND) || (state == S_WAIT_B);

`ifdef WBUF_WAIT_BRESP_EN
  assign b_ready = (state == S_WAIT_B);
`else
  logic b_ready_q;
  logic unused_b_valid;

  assign unused_b_valid = b_valid;

  // Response is never waited on: accept B as soon as reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_ready_q <= 1'b0;
    end else begin
      b_ready_q <= 1'b1;
    end
  end

  assign b_ready = b_ready_q;
`endif

endmodule

// File: tb/tb_write_buffer_d.sv
// tb/tb_write_buffer_d.sv - directed self-checking bench for write_buffer_d
module tb_write_buffer_d;

  localparam int NB = 16;

  logic            clk;
  logic            rstn;
  logic            wbuf_we;
  logic            wbuf_reset;
  logic            uncache;
  logic [32*NB-1:0] line_data;
  logic [31:0]     un_data;
  logic [3:0]      un_strb;
  logic            w_req;
  logic            w_rdy_AXI;
  logic            w_ready;
  logic            b_valid;
  logic            w_valid;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;
  logic            b_ready;
  logic            wrt_AXI_finish;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_d [NB];
  logic [3:0]  exp_s [NB];
  logic        exp_l [NB];

  write_buffer_d #(.LINE_BEATS(NB)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .wbuf_we        (wbuf_we),
    .wbuf_reset     (wbuf_reset),
    .uncache        (uncache),
    .line_data      (line_data),
    .un_data        (un_data),
    .un_strb        (un_strb),
    .w_req          (w_req),
    .w_rdy_AXI      (w_rdy_AXI),
    .w_ready        (w_ready),
    .b_valid        (b_valid),
    .w_valid        (w_valid),
    .w_data         (w_data),
    .w_strb         (w_strb),
    .w_last         (w_last),
    .b_ready        (b_ready),
    .wrt_AXI_finish (wrt_AXI_finish),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w_valid"}, w_valid, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_w_strb"}, w_strb, 0);
    check({tag, "_w_last"}, w_last, 0);
    check({tag, "_b_ready"}, b_ready, 0);
    check({tag, "_finish"}, wrt_AXI_finish, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic load(input logic [31:0] base, input logic unc,
                      input logic [31:0] ud, input logic [3:0] us);
    @(negedge clk);
    for (int i = 0; i < NB; i++) line_data[i*32 +: 32] = base + i;
    uncache = unc;
    un_data = ud;
    un_strb = us;
    wbuf_we = 1'b1;
    @(negedge clk);
    wbuf_we = 1'b0;
  endtask

  task automatic set_cached_exp(input logic [31:0] base);
    for (int i = 0; i < NB; i++) begin
      exp_d[i] = base + i;
      exp_s[i] = 4'hF;
      exp_l[i] = (i == NB - 1);
    end
  endtask

  task automatic start_send();
    check("full_no_valid", w_valid, 0);
    w_req     = 1'b1;
    w_rdy_AXI = 1'b1;
    @(negedge clk);
    w_req     = 1'b0;
    w_rdy_AXI = 1'b0;
    check("send_busy", busy, 1);
  endtask

  task automatic run_beats(input int n, input bit toggle, input bit inject);
    int beats = 0;
    int cyc = 0;
    while (beats < n && cyc < 100) begin
      check("w_valid", w_valid, 1);
      check($sformatf("w_data_%0d", beats), w_data, exp_d[beats]);
      check($sformatf("w_strb_%0d", beats), w_strb, exp_s[beats]);
      check($sformatf("w_last_%0d", beats), w_last, exp_l[beats]);
      if (inject && cyc == 3) begin
        for (int i = 0; i < NB; i++) line_data[i*32 +: 32] = 32'hBAD0_0000 + i;
        wbuf_we = 1'b1;
      end else begin
        wbuf_we = 1'b0;
      end
      w_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (w_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    w_ready = 1'b0;
    wbuf_we = 1'b0;
    check("hs_count", beats, n);
  endtask

  task automatic finish_seq();
`ifdef WBUF_WAIT_BRESP_EN
    check("waitb_b_ready", b_ready, 1);
    check("waitb_finish", wrt_AXI_finish, 0);
    check("waitb_busy", busy, 1);
    @(negedge clk);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    check("done_finish", wrt_AXI_finish, 1);
    check("done_b_ready", b_ready, 0);
    check("done_busy", busy, 0);
`else
    check("done_finish", wrt_AXI_finish, 1);
    check("done_b_ready", b_ready, 1);
    check("done_busy", busy, 0);
`endif
    check("done_no_valid", w_valid, 0);
  endtask

  task automatic release_buf();
    wbuf_reset = 1'b1;
    @(negedge clk);
    wbuf_reset = 1'b0;
    check("release_finish", wrt_AXI_finish, 0);
  endtask

  initial begin
    rstn       = 1'b0;
    wbuf_we    = 1'b0;
    wbuf_reset = 1'b0;
    uncache    = 1'b0;
    line_data  = '0;
    un_data    = '0;
    un_strb    = '0;
    w_req      = 1'b0;
    w_rdy_AXI  = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
`ifdef WBUF_WAIT_BRESP_EN
    check("idle_b_ready", b_ready, 0);
`else
    check("idle_b_ready", b_ready, 1);
`endif
    check("idle_busy", busy, 0);

    // Cached line, words 0..15, w_ready held high
    load(32'h0, 1'b0, 32'h0, 4'h0);
    set_cached_exp(32'h0);
    start_send();
    run_beats(NB, 1'b0, 1'b0);
    finish_seq();
    release_buf();

    // Uncached single-beat store
    load(32'h7000, 1'b1, 32'hDEADBEEF, 4'b0011);
    exp_d[0] = 32'hDEADBEEF;
    exp_s[0] = 4'b0011;
    exp_l[0] = 1'b1;
    start_send();
    run_beats(1, 1'b0, 1'b0);
    check("unc_single_beat", w_valid, 0);
    finish_seq();
    release_buf();

    // w_ready toggling, plus a capture attempt mid-burst that must be ignored
    load(32'h100, 1'b0, 32'h0, 4'h0);
    set_cached_exp(32'h100);
    start_send();
    run_beats(NB, 1'b1, 1'b1);
    finish_seq();
    release_buf();

    // Load then release without sending: FULL -> IDLE, no W traffic
    load(32'h300, 1'b0, 32'h0, 4'h0);
    check("full_valid", w_valid, 0);
    wbuf_reset = 1'b1;
    @(negedge clk);
    wbuf_reset = 1'b0;
    check("drop_valid", w_valid, 0);
    check("drop_busy", busy, 0);
    w_req     = 1'b1;
    w_rdy_AXI = 1'b1;
    @(negedge clk);
    w_req     = 1'b0;
    w_rdy_AXI = 1'b0;
    check("idle_ignores_wreq", w_valid, 0);
    @(negedge clk);
    check("idle_still_quiet", w_valid, 0);

    // DONE with capture and release together: capture wins
    load(32'h400, 1'b0, 32'h0, 4'h0);
    set_cached_exp(32'h400);
    start_send();
    run_beats(NB, 1'b0, 1'b0);
    finish_seq();
    for (int i = 0; i < NB; i++) line_data[i*32 +: 32] = 32'h500 + i;
    uncache    = 1'b0;
    wbuf_we    = 1'b1;
    wbuf_reset = 1'b1;
    @(negedge clk);
    wbuf_we    = 1'b0;
    wbuf_reset = 1'b0;
    check("we_wins_finish", wrt_AXI_finish, 0);
    set_cached_exp(32'h500);
    start_send();
    run_beats(5, 1'b0, 1'b0);
    check("beat5_data", w_data, 32'h505);

    // Asynchronous reset mid-burst
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    check("post_rst_valid", w_valid, 0);
    @(negedge clk);
    w_req     = 1'b1;
    w_rdy_AXI = 1'b1;
    @(negedge clk);
    w_req     = 1'b0;
    w_rdy_AXI = 1'b0;
    check("post_rst_idle", w_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_finish", wrt_AXI_finish, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
